// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared state encodings and defaults for the pipeline hazard controller
package hazard_stall_ctrl_pkg;
  localparam int REG_W_DEF = 5;
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERROR    = 2'd2
  } haz_state_e;
endpackage

// File: rtl/haz_perf_counter.sv
// haz_perf_counter: saturating event counter, clears on async reset
module haz_perf_counter #(
  parameter int W = 16
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (en && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stalls, EX branch/jump flushes and memory-busy freeze with watchdog.
// Optional saturating perf counters (stall_cycles, flush_count) when HAZ_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 15
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W     = 16
`endif
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
`ifdef HAZ_PERF_CNT_EN
  output logic [1:0]       haz_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`else
  output logic [1:0]       haz_state
`endif
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  haz_state_e state;
  logic [CW-1:0] wait_cnt;
  logic load_use, ctl_flush, freeze, live, flush, bubble;
  assign load_use  = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign ctl_flush = ex_valid & (ex_branch_taken | ex_jump);
  // Outputs are forced low while rst_n is asserted, independent of the clock.
  assign freeze = rst_n & ((state == HZ_ERROR) | ((state == HZ_MEM_WAIT) & !mem_ack) |
                           ((state == HZ_RUN) & mem_req & !mem_ack));
  assign live   = rst_n & !freeze & ((state == HZ_RUN) | (state == HZ_MEM_WAIT));
  assign flush  = live & ctl_flush;
  assign bubble = live & !ctl_flush & load_use;
  assign pc_stall    = freeze | bubble;
  assign ifid_stall  = freeze | bubble;
  assign idex_stall  = freeze;
  assign exmem_stall = freeze;
  assign ifid_flush  = flush;
  assign idex_flush  = flush | bubble;
  assign haz_state   = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= HZ_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        HZ_RUN:
          if (mem_req && !mem_ack) begin
            state    <= HZ_MEM_WAIT;
            wait_cnt <= CW'(1);
          end
        HZ_MEM_WAIT:
          if (mem_ack) begin
            state    <= HZ_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CW'(MEM_TIMEOUT)) begin
            state       <= HZ_ERROR;
            mem_timeout <= 1'b1;
          end else wait_cnt <= wait_cnt + 1'b1;
        HZ_ERROR: state <= HZ_ERROR;
        default: state <= HZ_RUN;
      endcase
    end
`ifdef HAZ_PERF_CNT_EN
  haz_perf_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .en(pc_stall), .count(stall_cycles));
  haz_perf_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .en(ifid_flush), .count(flush_count));
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and randomized checks of hazard_stall_ctrl against a behavioural model
module tb_hazard_stall_ctrl;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0;
  logic id_valid, id_uses_rt, ex_valid, ex_mem_read, ex_branch_taken, ex_jump, mem_req, mem_ack;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, mem_timeout;
  logic [1:0] haz_state;
  logic [5:0] obs, exp_o;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count;
`endif
  int checks = 0, errors = 0;
  bit m_wait, m_dead;
  int m_cnt, m_stalls, m_flushes;

  hazard_stall_ctrl #(.REG_W(5), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mem_timeout(mem_timeout),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .haz_state(haz_state));

  assign obs = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};
  always #5 clk = ~clk;

  // Expected {pc,ifid,idex,exmem stalls, ifid,idex flushes} from the documented rules.
  function automatic logic [5:0] model_out();
    bit lu, cf, frz;
    if (!rst_n) return 6'b0;
    lu  = id_valid && ex_valid && ex_mem_read && ex_rt != 0 &&
          (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    cf  = ex_valid && (ex_branch_taken || ex_jump);
    frz = m_dead || (m_wait ? !mem_ack : (mem_req && !mem_ack));
    if (frz) return 6'b111100;
    if (cf) return 6'b000011;
    if (lu) return 6'b110001;
    return 6'b0;
  endfunction

  function automatic logic [1:0] model_state();
    return m_dead ? 2'd2 : m_wait ? 2'd1 : 2'd0;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_dead = 0; m_cnt = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic tick();
    logic [5:0] e;
    e = model_out();
    if (e[5]) m_stalls++;
    if (e[1]) m_flushes++;
    @(posedge clk);
    if (!m_dead) begin
      if (!m_wait) begin
        if (mem_req && !mem_ack) begin m_wait = 1; m_cnt = 1; end
      end else if (mem_ack) m_wait = 0;
      else if (m_cnt == TO) m_dead = 1;
      else m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_valid = 0; ex_mem_read = 0;
    ex_rt = 0; ex_branch_taken = 0; ex_jump = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic test_reset();
    idle(); mem_req = 1; ex_valid = 1; ex_jump = 1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (obs !== 6'b0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 6'b0); end
    checks++; if (haz_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", haz_state); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout); end
    idle();
    #3 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    idle(); ex_valid = 1; ex_mem_read = 1; ex_rt = 8; id_valid = 1; id_rs = 8; id_rt = 3; id_uses_rt = 1;
    #1;
    checks++; if (obs !== 6'b110001) begin errors++; $display("FAIL load_use_stall: got %b expected %b", obs, 6'b110001); end
    tick();
    ex_valid = 0; ex_mem_read = 0;
    #1;
    checks++; if (obs !== 6'b0) begin errors++; $display("FAIL load_use_bubble_once: got %b expected %b", obs, 6'b0); end
    tick();
    idle(); ex_valid = 1; ex_mem_read = 1; ex_rt = 5; id_valid = 1; id_rs = 1; id_rt = 5; id_uses_rt = 1;
    #1;
    checks++; if (obs !== 6'b110001) begin errors++; $display("FAIL load_use_rt: got %b expected %b", obs, 6'b110001); end
    tick();
  endtask

  task automatic test_r0_no_use();
    idle(); ex_valid = 1; ex_mem_read = 1; ex_rt = 0; id_valid = 1; id_rs = 0; id_uses_rt = 1;
    #1;
    checks++; if (obs !== 6'b0) begin errors++; $display("FAIL r0_no_stall: got %b expected %b", obs, 6'b0); end
    tick();
    ex_rt = 9; id_rs = 2; id_rt = 9; id_uses_rt = 0;
    #1;
    checks++; if (obs !== 6'b0) begin errors++; $display("FAIL rt_unused_no_stall: got %b expected %b", obs, 6'b0); end
    tick();
  endtask

  task automatic test_branch_over_load_use();
    idle(); ex_valid = 1; ex_mem_read = 1; ex_rt = 8; id_valid = 1; id_rs = 8; ex_branch_taken = 1;
    #1;
    checks++; if (obs !== 6'b000011) begin errors++; $display("FAIL branch_over_load_use: got %b expected %b", obs, 6'b000011); end
    tick();
  endtask

  task automatic test_mem_wait();
    idle(); mem_req = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (obs !== 6'b111100) begin errors++; $display("FAIL mem_wait_freeze%0d: got %b expected %b", k, obs, 6'b111100); end
      checks++; if (haz_state !== (k == 0 ? 2'd0 : 2'd1)) begin errors++; $display("FAIL mem_wait_state%0d: got %0d expected %0d", k, haz_state, k == 0 ? 0 : 1); end
      tick();
    end
    mem_ack = 1; ex_valid = 1; ex_jump = 1;
    #1;
    checks++; if (obs !== 6'b000011) begin errors++; $display("FAIL mem_ack_deferred_flush: got %b expected %b", obs, 6'b000011); end
    tick();
    idle();
    #1;
    checks++; if (haz_state !== 2'd0 || obs !== 6'b0) begin errors++; $display("FAIL mem_wait_exit: got state %0d out %b expected state 0 out 0", haz_state, obs); end
    tick();
  endtask

  task automatic test_timeout();
    logic [1:0] st [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    idle(); mem_req = 1;
    for (int k = 0; k < 7; k++) begin
      mem_ack = (k == 6);
      #1;
      checks++; if (obs !== 6'b111100) begin errors++; $display("FAIL timeout_freeze%0d: got %b expected %b", k, obs, 6'b111100); end
      checks++; if (haz_state !== st[k]) begin errors++; $display("FAIL timeout_state%0d: got %0d expected %0d", k, haz_state, st[k]); end
      checks++; if (mem_timeout !== (k >= 5)) begin errors++; $display("FAIL timeout_flag%0d: got %b expected %b", k, mem_timeout, k >= 5); end
      tick();
    end
    rst_n = 0; #1;
    checks++; if (obs !== 6'b0 || haz_state !== 2'd0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_reset_clear: got out %b state %0d to %b expected 0 0 0", obs, haz_state, mem_timeout); end
    model_reset(); idle();
    #2 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    idle(); mem_req = 1;
    tick(); tick();
    #2 rst_n = 0; #1;
    checks++; if (obs !== 6'b0 || haz_state !== 2'd0) begin errors++; $display("FAIL async_reset: got out %b state %0d expected 0 0", obs, haz_state); end
`ifdef HAZ_PERF_CNT_EN
    checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL async_reset_perf: got %0d %0d expected 0 0", stall_cycles, flush_count); end
`endif
    model_reset(); idle();
    @(posedge clk); #1 rst_n = 1;
    #1;
    checks++; if (obs !== 6'b0 || haz_state !== 2'd0) begin errors++; $display("FAIL async_reset_release: got out %b state %0d expected 0 0", obs, haz_state); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if (m_dead && ($urandom_range(0, 3) == 0)) begin
        idle(); rst_n = 0; #1; model_reset();
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
      end
      id_valid = $urandom_range(0, 1); id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = $urandom_range(0, 1); ex_valid = $urandom_range(0, 1); ex_mem_read = $urandom_range(0, 1);
      ex_rt = 5'($urandom_range(0, 3)); ex_branch_taken = ($urandom_range(0, 4) == 0);
      ex_jump = ($urandom_range(0, 5) == 0); mem_req = ($urandom_range(0, 3) == 0);
      mem_ack = ($urandom_range(0, 2) != 0);
      #1;
      exp_o = model_out();
      checks++; if (obs !== exp_o) begin errors++; $display("FAIL rand_out%0d: got %b expected %b", n, obs, exp_o); end
      checks++; if (haz_state !== model_state()) begin errors++; $display("FAIL rand_state%0d: got %0d expected %0d", n, haz_state, model_state()); end
      checks++; if (mem_timeout !== m_dead) begin errors++; $display("FAIL rand_timeout%0d: got %b expected %b", n, mem_timeout, m_dead); end
      tick();
    end
`ifdef HAZ_PERF_CNT_EN
    checks++; if (stall_cycles !== 16'(m_stalls) || flush_count !== 16'(m_flushes)) begin errors++; $display("FAIL rand_perf: got %0d %0d expected %0d %0d", stall_cycles, flush_count, m_stalls, m_flushes); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_r0_no_use();
    test_branch_over_load_use();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: run did not complete within time limit");
    $fatal(1);
  end
endmodule
